// File: rtl/fs_inst_queue.sv
// Fetch-to-decode instruction queue with branch pre-decode and delay-slot tagging.
// Latency: 1 cycle push-to-head (0 cycles when FS_BUF_BYPASS_EN and the queue is empty).
// Backpressure: buf_allowin = !full from registered count only; ds_allowin stalls the head.
//
// Ports:
//   clk, resetn          single clock, asynchronous active-low reset
//   flush                discard all entries and the delay-slot flag
//   fs_to_buf_valid      push request {fs_pc, fs_inst}; accepted when buf_allowin
//   buf_to_ds_valid      head valid; buf_to_ds_bus = {bd, pc, inst}
//   buf_head_is_br       head is a branch/jump (its successor is a delay slot)
//   ds_allowin           decode consumes the head this cycle
// Optional macro: FS_BUF_BYPASS_EN -- empty queue forwards fetch straight to decode.
module fs_inst_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        fs_to_buf_valid,
    input  logic [31:0] fs_pc,
    input  logic [31:0] fs_inst,
    output logic        buf_allowin,
    output logic        buf_to_ds_valid,
    output logic [64:0] buf_to_ds_bus,
    output logic        buf_head_is_br,
    input  logic        ds_allowin
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W:0]   count;
    logic             slot_flag;

    logic   full, empty, bypass;
    logic   push, mem_pop, deliver;
    entry_t head;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

`ifdef FS_BUF_BYPASS_EN
    // Empty queue with a consumer ready: hand the fetched word straight through.
    assign bypass = empty & fs_to_buf_valid & ds_allowin & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign buf_allowin     = ~full;
    assign buf_to_ds_valid = ~empty | bypass;

    always_comb begin
        head = '0;
        if (bypass) begin
            head.pc   = fs_pc;
            head.inst = fs_inst;
        end else if (!empty) begin
            head = mem[rptr];
        end
    end

    assign buf_to_ds_bus = {slot_flag & buf_to_ds_valid, head.pc, head.inst};

    // A bypassed word is delivered, never stored, so it is neither pushed nor popped.
    assign push    = fs_to_buf_valid & buf_allowin & ~bypass;
    assign deliver = buf_to_ds_valid & ds_allowin;
    assign mem_pop = deliver & ~bypass;

    // Branch/jump pre-decode of the head instruction.
    logic [5:0] op, func;
    logic [4:0] rt, rd, sa;
    always_comb begin
        op   = head.inst[31:26];
        rt   = head.inst[20:16];
        rd   = head.inst[15:11];
        sa   = head.inst[10:6];
        func = head.inst[5:0];
        buf_head_is_br = 1'b0;
        case (op)
            6'h02, 6'h03, 6'h04, 6'h05: buf_head_is_br = 1'b1;
            6'h01: buf_head_is_br = (rt == 5'h00) | (rt == 5'h01) |
                                    (rt == 5'h10) | (rt == 5'h11);
            6'h06, 6'h07: buf_head_is_br = (rt == 5'h00);
            6'h00: buf_head_is_br =
                ((func == 6'h08) & (rt == 5'h00) & (rd == 5'h00) & (sa == 5'h00)) |
                ((func == 6'h09) & (rt == 5'h00) & (sa == 5'h00));
            default: buf_head_is_br = 1'b0;
        endcase
        if (!buf_to_ds_valid) buf_head_is_br = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
            slot_flag <= 1'b0;
        end else if (flush) begin
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
            slot_flag <= 1'b0;
        end else begin
            if (push)    wptr <= wptr + PTR_ONE;
            if (mem_pop) rptr <= rptr + PTR_ONE;
            case ({push, mem_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // The word after any delivered branch is its delay slot.
            if (deliver) slot_flag <= buf_head_is_br;
        end
    end

    // Storage carries no reset; validity lives entirely in count.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wptr].pc   <= fs_pc;
            mem[wptr].inst <= fs_inst;
        end
    end

endmodule
